// File: rtl/dataram_arbiter.sv
// Two-port arbiter and sequencer for the byte-addressed data RAM: latches one
// command at a time, runs a single RAM access cycle and returns extended read data.
module dataram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic              uns0,
    input  logic              uns1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [1:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitration happens here
    // ACCESS | single RAM cycle driven from the latched command
    // RESP   | RAM read data valid; result registered on exit
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_last;
    logic              r_port;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err_cmd;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic              r_err;
    logic [31:0]       r_rdata;

    logic              w_any_req;
    logic              w_pick1;
    logic              w_we;
    logic [1:0]        w_size;
    logic              w_uns;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic              w_illegal;
    logic [31:0]       w_load;

    assign w_any_req = req0 | req1;

    // r_last = 1 means port 1 won the previous arbitration
    always_comb begin
        w_pick1 = 1'b0;
        if (req1 && !req0) begin
            w_pick1 = 1'b1;
        end else if (req1 && req0) begin
            w_pick1 = (FIXED_PRIO == 0) ? !r_last : 1'b0;
        end
    end

    always_comb begin
        w_we      = w_pick1 ? we1    : we0;
        w_size    = w_pick1 ? size1  : size0;
        w_uns     = w_pick1 ? uns1   : uns0;
        w_addr    = w_pick1 ? addr1  : addr0;
        w_wdata   = w_pick1 ? wdata1 : wdata0;
        w_illegal = (w_size == 2'd3) ||
                    ((w_size == 2'd1) && w_addr[0]) ||
                    ((w_size == 2'd2) && (w_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next = w_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Only the bytes selected by the access size may reach rdata
    always_comb begin
        w_load = '0;
        if (!r_err_cmd && !r_we) begin
            case (r_size)
                2'd0:    w_load = {{24{!r_uns && ram_rdata[7]}}, ram_rdata[7:0]};
                2'd1:    w_load = {{16{!r_uns && ram_rdata[15]}}, ram_rdata[15:0]};
                2'd2:    w_load = ram_rdata;
                default: w_load = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= 1'b1;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_size    <= 2'd0;
            r_uns     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err_cmd <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            if ((r_state == S_IDLE) && w_any_req) begin
                r_port    <= w_pick1;
                r_last    <= w_pick1;
                r_we      <= w_we;
                r_size    <= w_size;
                r_uns     <= w_uns;
                r_addr    <= w_addr;
                r_wdata   <= w_wdata;
                r_err_cmd <= w_illegal;
                r_gnt0    <= !w_pick1;
                r_gnt1    <= w_pick1;
            end
            if (r_state == S_RESP) begin
                r_rdata <= w_load;
                r_done0 <= !r_port;
                r_done1 <= r_port;
                r_err   <= r_err_cmd;
            end
        end
    end

    always_comb begin
        ram_we = r_we && (r_state == S_ACCESS) && !rst;
        busy   = (r_state != S_IDLE);
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign ram_sel   = r_size;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_dataram_arbiter.sv
// Bench for dataram_arbiter: directed vector table, arbitration/reset sequences
// and a randomized run against a byte-array reference model.
module tb_dataram_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, fp_req0, fp_req1;
    logic          we0, we1, uns0, uns1;
    logic [1:0]    size0, size1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   wdata0, wdata1;

    logic          gnt0, gnt1, done0, done1, err, busy, ram_we;
    logic [31:0]   rdata, ram_wdata, ram_rdata;
    logic [1:0]    ram_sel;
    logic [AW-1:0] ram_addr;

    logic          fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_err, fp_busy, fp_ram_we;
    logic [31:0]   fp_rdata, fp_ram_wdata, fp_ram_rdata;
    logic [1:0]    fp_ram_sel;
    logic [AW-1:0] fp_ram_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram     [0:1023];
    logic [7:0] ref_mem [0:1023];

    always #5 clk = ~clk;
    assign fp_ram_rdata = 32'h8000_00F0;

    dataram_arbiter #(.ADDR_W(AW), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .size0(size0), .size1(size1), .uns0(uns0), .uns1(uns1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .rdata(rdata), .busy(busy), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    dataram_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .req0(fp_req0), .req1(fp_req1), .we0(we0), .we1(we1),
        .size0(size0), .size1(size1), .uns0(uns0), .uns1(uns1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1), .err(fp_err),
        .rdata(fp_rdata), .busy(fp_busy), .ram_sel(fp_ram_sel), .ram_addr(fp_ram_addr),
        .ram_wdata(fp_ram_wdata), .ram_we(fp_ram_we), .ram_rdata(fp_ram_rdata)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd2) ? 4 : (s == 2'd1) ? 2 : 1;
    endfunction

    // RAM model: falling-edge byte writes, registered read with junk in unused bytes
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = init_byte(i);
        forever begin
            @(negedge clk);
            if (ram_we) begin
                for (int k = 0; k < nbytes(ram_sel); k++)
                    ram[(int'(ram_addr) + k) % 1024] = ram_wdata[8*k +: 8];
            end
        end
    end

    function automatic logic [31:0] rd_word(input logic [AW-1:0] a, input logic [1:0] s);
        logic [31:0] v;
        v = $urandom;
        for (int k = 0; k < nbytes(s); k++) v[8*k +: 8] = ram[(int'(a) + k) % 1024];
        return v;
    endfunction

    always @(posedge clk) ram_rdata <= rd_word(ram_addr, ram_sel);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: load value from the byte array, extended by plain arithmetic
    function automatic logic [31:0] model_load(input logic [AW-1:0] a, input logic [1:0] s,
                                               input logic u);
        longint unsigned v = 0;
        int n = nbytes(s);
        for (int k = 0; k < n; k++) v += longint'(ref_mem[(int'(a) + k) % 1024]) << (8 * k);
        if (!u && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (64'd1 << (8 * n)) ;
        return v[31:0];
    endfunction

    task automatic drive_port(input int p, input logic r, input logic w, input logic [1:0] s,
                              input logic u, input logic [AW-1:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; size0 = s; uns0 = u; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; size1 = s; uns1 = u; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 0; req1 = 0; fp_req0 = 0; fp_req1 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One access on the round-robin instance; latencies counted in cycles from request
    task automatic do_access(input int p, input logic w, input logic [1:0] s, input logic u,
                             input logic [AW-1:0] a, input logic [31:0] d,
                             output int lat_g, output int lat_d, output logic e,
                             output logic [31:0] rd, output int n_we, output int we_at,
                             output int spur);
        lat_g = -1; lat_d = -1; e = 1'b0; rd = '0; n_we = 0; we_at = -1; spur = 0;
        @(negedge clk);
        drive_port(1 - p, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
        drive_port(p, 1'b1, w, s, u, a, d);
        for (int i = 1; i <= 10 && lat_d < 0; i++) begin
            @(negedge clk);
            if (ram_we) begin n_we++; we_at = i; end
            if ((p == 0 ? gnt1 : gnt0) || (p == 0 ? done1 : done0)) spur++;
            if ((p == 0 ? gnt0 : gnt1) && lat_g < 0) begin
                lat_g = i;
                if (p == 0) req0 = 1'b0; else req1 = 1'b0;
            end
            if (p == 0 ? done0 : done1) begin
                lat_d = i; e = err; rd = rdata;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    initial begin
        int lg, ld, nwe, weat, spur;
        logic e;
        logic [31:0] rd;

        vt[0]  = '{0, 1'b1, 2'd2, 1'b0, 10'h028, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[1]  = '{1, 1'b0, 2'd0, 1'b0, 10'h028, 32'h0,        1'b0, 32'hFFFFFFEF};
        vt[2]  = '{1, 1'b0, 2'd1, 1'b1, 10'h02A, 32'h0,        1'b0, 32'h0000DEAD};
        vt[3]  = '{1, 1'b0, 2'd2, 1'b0, 10'h028, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[4]  = '{0, 1'b1, 2'd2, 1'b0, 10'h029, 32'h11111111, 1'b1, 32'h0};
        vt[5]  = '{1, 1'b1, 2'd3, 1'b0, 10'h028, 32'h22222222, 1'b1, 32'h0};
        vt[6]  = '{0, 1'b0, 2'd2, 1'b1, 10'h028, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[7]  = '{0, 1'b1, 2'd2, 1'b0, 10'h040, 32'hAABBCCDD, 1'b0, 32'h0};
        vt[8]  = '{0, 1'b1, 2'd1, 1'b0, 10'h040, 32'h00001234, 1'b0, 32'h0};
        vt[9]  = '{1, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0,        1'b0, 32'hAABB1234};
        vt[10] = '{0, 1'b0, 2'd0, 1'b1, 10'h041, 32'h0,        1'b0, 32'h00000012};
        vt[11] = '{0, 1'b0, 2'd1, 1'b0, 10'h042, 32'h0,        1'b0, 32'hFFFFAABB};
        vt[12] = '{1, 1'b0, 2'd1, 1'b0, 10'h041, 32'h0,        1'b1, 32'h0};
        vt[13] = '{1, 1'b0, 2'd0, 1'b0, 10'h029, 32'h0,        1'b0, 32'hFFFFFFBE};
        vt[14] = '{0, 1'b0, 2'd3, 1'b1, 10'h040, 32'h0,        1'b1, 32'h0};

        rst = 1'b1; req0 = 0; req1 = 0; fp_req0 = 0; fp_req1 = 0;
        we0 = 0; we1 = 0; size0 = 0; size1 = 0; uns0 = 0; uns1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);

        do_reset();
        check("reset_outputs", {gnt0, gnt1, done0, done1, err, busy, ram_we}, 7'b0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_cmd", {ram_sel, ram_addr, ram_wdata}, 44'h0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            do_access(vt[i].port, vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd,
                      lg, ld, e, rd, nwe, weat, spur);
            check($sformatf("vec%0d_gnt_lat", i), lg, 1);
            check($sformatf("vec%0d_done_lat", i), ld, vt[i].exp_err ? 2 : 3);
            check($sformatf("vec%0d_err", i), e, vt[i].exp_err);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_we_cycles", i), nwe, (vt[i].we && !vt[i].exp_err) ? 1 : 0);
            check($sformatf("vec%0d_other_port", i), spur, 0);
            if (nwe == 1) check($sformatf("vec%0d_we_at", i), weat, 1);
        end

        // Both ports held: alternation (round-robin) vs port 0 only (fixed priority)
        begin
            int rr_g[$], rr_t[$], fp_g[$], fp_t[$];
            int fp_dn = 0;
            do_reset();
            @(negedge clk);
            drive_port(0, 1'b1, 1'b0, 2'd2, 1'b0, 10'h028, 32'h5A5A0000);
            drive_port(1, 1'b1, 1'b0, 2'd2, 1'b0, 10'h02C, 32'h0);
            fp_req0 = 1'b1; fp_req1 = 1'b1;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (gnt0 || gnt1) begin
                    rr_g.push_back(gnt1 ? 1 : 0); rr_t.push_back(i);
                    if (rr_g.size() == 6) begin req0 = 1'b0; req1 = 1'b0; end
                end
                if (fp_gnt0 || fp_gnt1) begin
                    fp_g.push_back(fp_gnt1 ? 1 : 0); fp_t.push_back(i);
                    if (fp_g.size() == 6) begin fp_req0 = 1'b0; fp_req1 = 1'b0; end
                end
                if (fp_done0 || fp_done1) begin
                    fp_dn++;
                    check("fp_done_err", fp_err, 1'b0);
                    check("fp_done_rdata", fp_rdata, 32'h800000F0);
                end
            end
            check("rr_grant_count", rr_g.size(), 6);
            check("fp_grant_count", fp_g.size(), 6);
            for (int k = 0; k < rr_g.size(); k++) begin
                check($sformatf("rr_grant%0d_port", k), rr_g[k], k % 2);
                if (k > 0) check($sformatf("rr_grant%0d_gap", k), rr_t[k] - rr_t[k-1], 3);
            end
            for (int k = 0; k < fp_g.size(); k++) begin
                check($sformatf("fp_grant%0d_port", k), fp_g[k], 0);
                if (k > 0) check($sformatf("fp_grant%0d_gap", k), fp_t[k] - fp_t[k-1], 3);
            end
            check("fp_done_count", fp_dn, 6);
            check("fp_latched_cmd", {fp_ram_sel, fp_ram_addr, fp_ram_wdata},
                  {2'd2, 10'h028, 32'h5A5A0000});
            check("fp_idle_after", {fp_busy, fp_ram_we}, 2'b00);
        end

        // Reset during the ACCESS cycle of a store
        begin
            int seen_done = 0;
            do_reset();
            @(negedge clk);
            drive_port(0, 1'b1, 1'b1, 2'd0, 1'b0, 10'h050, 32'h00000077);
            @(posedge clk);
            #1;
            req0 = 1'b0;
            rst  = 1'b1;
            @(negedge clk);
            check("rstacc_gnt0", gnt0, 1'b1);
            check("rstacc_ram_we", ram_we, 1'b0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            check("rstacc_busy", busy, 1'b0);
            for (int i = 0; i < 5; i++) begin
                if (done0 || done1) seen_done++;
                @(negedge clk);
            end
            check("rstacc_no_done", seen_done, 0);
            check("rstacc_ram_byte", ram[10'h050], init_byte(10'h050));
            do_access(1, 1'b0, 2'd0, 1'b1, 10'h050, 32'h0, lg, ld, e, rd, nwe, weat, spur);
            check("rstacc_next_gnt_lat", lg, 1);
            check("rstacc_next_done_lat", ld, 3);
            check("rstacc_next_rdata", rd, {24'h0, init_byte(10'h050)});
        end

        // Randomized traffic on both ports against the reference model
        begin
            logic        c_we [2];
            logic [1:0]  c_sz [2];
            logic        c_u  [2];
            logic [9:0]  c_a  [2];
            logic [31:0] c_d  [2];
            logic        act  [2];
            int          idle [2];
            int          waitc[2];
            bit          pend = 0;
            int          pend_port = 0, pend_due = 0, last_w = 1;
            logic        pend_err = 0;
            logic [31:0] pend_rd = 0;
            do_reset();
            for (int p = 0; p < 2; p++) begin act[p] = 0; idle[p] = p; waitc[p] = 0; end
            for (int cyc = 0; cyc < 2000; cyc++) begin
                @(negedge clk);
                if (done0 || done1) begin
                    check("rand_done_port", {done1, done0}, pend_port == 1 ? 2'b10 : 2'b01);
                    check("rand_done_cycle", cyc, pend ? pend_due : -1);
                    check("rand_done_err", err, pend_err);
                    check("rand_done_rdata", rdata, pend_rd);
                    pend = 0;
                end else if (pend && cyc > pend_due) begin
                    check("rand_done_timeout", 0, 1);
                    pend = 0;
                end
                if (gnt0 || gnt1) begin
                    int w, exp_w;
                    bit legal;
                    w = gnt1 ? 1 : 0;
                    if (act[0] && act[1]) exp_w = (last_w == 0) ? 1 : 0;
                    else exp_w = act[1] ? 1 : 0;
                    check("rand_gnt", {gnt1, gnt0}, exp_w == 1 ? 2'b10 : 2'b01);
                    check("rand_gnt_while_pending", pend, 1'b0);
                    last_w = exp_w;
                    legal = (c_sz[w] != 2'd3) && ((int'(c_a[w]) % nbytes(c_sz[w])) == 0);
                    check("rand_ram_we", ram_we, legal && c_we[w]);
                    pend      = 1;
                    pend_port = w;
                    pend_err  = !legal;
                    pend_due  = cyc + (legal ? 2 : 1);
                    pend_rd   = (legal && !c_we[w]) ? model_load(c_a[w], c_sz[w], c_u[w]) : 32'h0;
                    if (legal && c_we[w])
                        for (int k = 0; k < nbytes(c_sz[w]); k++)
                            ref_mem[(int'(c_a[w]) + k) % 1024] = 8'(c_d[w] >> (8 * k));
                    act[w] = 0;
                    idle[w] = $urandom_range(0, 4);
                    drive_port(w, 1'b0, c_we[w], c_sz[w], c_u[w], c_a[w], c_d[w]);
                end else begin
                    check("rand_ram_we_idle", ram_we, 1'b0);
                end
                for (int p = 0; p < 2; p++) begin
                    if (act[p]) begin
                        waitc[p]++;
                        if (waitc[p] > 12) begin
                            check($sformatf("rand_port%0d_starved", p), waitc[p], 12);
                            act[p] = 0;
                            drive_port(p, 1'b0, c_we[p], c_sz[p], c_u[p], c_a[p], c_d[p]);
                        end
                    end else if (idle[p] > 0) begin
                        idle[p]--;
                    end else begin
                        int base;
                        c_we[p] = 1'($urandom_range(0, 1));
                        c_u[p]  = 1'($urandom_range(0, 1));
                        c_sz[p] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                        base    = $urandom_range(0, 63);
                        if ($urandom_range(0, 3) != 0 && c_sz[p] != 2'd3)
                            base = base - (base % nbytes(c_sz[p]));
                        c_a[p]  = 10'(256 + base);
                        c_d[p]  = $urandom;
                        act[p]  = 1;
                        waitc[p] = 0;
                        drive_port(p, 1'b1, c_we[p], c_sz[p], c_u[p], c_a[p], c_d[p]);
                    end
                end
            end
            req0 = 1'b0; req1 = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
